branch_unit_bht: RTL and testbench

Parametrised branch resolution unit with a direct-mapped branch history table (BHT) of 2-bit saturating counters. It serves two stages. In IF, it supplies a taken/not-taken prediction per fetch PC. In EX, it evaluates the full MIPS conditional-branch set with signed comparisons, updates the BHT, and raises a registered one-cycle flush/redirect on misprediction. Saturating performance counters track resolved branches and mispredictions.

---
 rtl/branch_unit_bht_if.sv | 30 +++
 rtl/branch_unit_bht.sv | 96 +++++++++
 tb/tb_branch_unit_bht.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_unit_bht_if.sv
// rtl/branch_unit_bht_if.sv - EX-stage branch resolution bus between pipeline and branch unit
interface branch_unit_bht_if #(
  parameter int DATA_W = 32
);
  logic              ex_valid;
  logic              ex_stall;
  logic              ex_branch;
  logic [3:0]        ex_branch_op;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_pc;
  logic              ex_pred_taken;
  logic [DATA_W-1:0] ex_target;
  logic [DATA_W-1:0] ex_fallthru;
  logic              branch_en;
  logic              flush;
  logic [DATA_W-1:0] redirect_pc;

  modport master (
    output ex_valid, ex_stall, ex_branch, ex_branch_op, ex_rs_data, ex_rt_data,
           ex_pc, ex_pred_taken, ex_target, ex_fallthru,
    input  branch_en, flush, redirect_pc
  );

  modport slave (
    input  ex_valid, ex_stall, ex_branch, ex_branch_op, ex_rs_data, ex_rt_data,
           ex_pc, ex_pred_taken, ex_target, ex_fallthru,
    output branch_en, flush, redirect_pc
  );
endinterface

// File: rtl/branch_unit_bht.sv
// rtl/branch_unit_bht.sv - branch resolution unit with 2-bit counter BHT and mispredict flush
module branch_unit_bht #(
  parameter int DATA_W      = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [DATA_W-1:0]  if_pc,
  output logic               if_pred_taken,
  branch_unit_bht_if.slave   ex,
  output logic [CNT_W-1:0]   stat_branches,
  output logic [CNT_W-1:0]   stat_mispred
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [3:0] OP_BEQ  = 4'b0001;
  localparam logic [3:0] OP_BNE  = 4'b0010;
  localparam logic [3:0] OP_BGEZ = 4'b0011;
  localparam logic [3:0] OP_BGTZ = 4'b0100;
  localparam logic [3:0] OP_BLEZ = 4'b0101;
  localparam logic [3:0] OP_BLTZ = 4'b0110;
  localparam logic [3:0] OP_J    = 4'b0111;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             taken;
  logic             cond_op;
  logic             resolve;
  logic             mispred;

  assign if_idx = if_pc[IDX_LSB+IDX_W-1:IDX_LSB];
  assign ex_idx = ex.ex_pc[IDX_LSB+IDX_W-1:IDX_LSB];

  // Prediction is the counter MSB; the read sees the pre-update value.
  assign if_pred_taken = bht[if_idx][1];

  // Evaluate the branch condition on signed operands.
  always_comb begin
    taken   = 1'b0;
    cond_op = 1'b0;
    case (ex.ex_branch_op)
      OP_BEQ:  begin cond_op = 1'b1; taken = (ex.ex_rs_data == ex.ex_rt_data); end
      OP_BNE:  begin cond_op = 1'b1; taken = (ex.ex_rs_data != ex.ex_rt_data); end
      OP_BGEZ: begin cond_op = 1'b1; taken = ($signed(ex.ex_rs_data) >= 0); end
      OP_BGTZ: begin cond_op = 1'b1; taken = ($signed(ex.ex_rs_data) > 0); end
      OP_BLEZ: begin cond_op = 1'b1; taken = ($signed(ex.ex_rs_data) <= 0); end
      OP_BLTZ: begin cond_op = 1'b1; taken = ($signed(ex.ex_rs_data) < 0); end
      OP_J:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign ex.branch_en = ex.ex_branch & taken;

  // The instruction in EX during a flush cycle is wrong-path and is ignored.
  assign resolve = ex.ex_valid & ex.ex_branch & ~ex.ex_stall & ~ex.flush;
  assign mispred = resolve & (ex.branch_en != ex.ex_pred_taken);

  // Train the saturating counter of the resolved conditional branch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (resolve && cond_op) begin
      if (ex.branch_en) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

  // One-cycle flush pulse carrying the correct-path PC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex.flush       <= 1'b0;
      ex.redirect_pc <= '0;
    end else begin
      ex.flush <= mispred;
      if (mispred) ex.redirect_pc <= ex.branch_en ? ex.ex_target : ex.ex_fallthru;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (resolve && (stat_branches != {CNT_W{1'b1}})) stat_branches <= stat_branches + 1'b1;
      if (mispred && (stat_mispred != {CNT_W{1'b1}}))  stat_mispred  <= stat_mispred + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_unit_bht.sv
// tb/tb_branch_unit_bht.sv - directed self-checking bench for branch_unit_bht
module tb_branch_unit_bht;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [DATA_W-1:0] if_pc;
  logic              if_pred_taken;
  logic [CNT_W-1:0]  stat_branches;
  logic [CNT_W-1:0]  stat_mispred;

  int checks = 0;
  int errors = 0;

  branch_unit_bht_if #(.DATA_W(DATA_W)) bus ();

  branch_unit_bht #(
    .DATA_W(DATA_W), .BHT_ENTRIES(64), .IDX_LSB(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex(bus), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid = 1'b0; bus.ex_stall = 1'b0; bus.ex_branch = 1'b0;
    bus.ex_branch_op = 4'd0; bus.ex_rs_data = '0; bus.ex_rt_data = '0;
    bus.ex_pc = '0; bus.ex_pred_taken = 1'b0; bus.ex_target = '0; bus.ex_fallthru = '0;
  endtask

  task automatic drive_br(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] pc, input logic pred);
    bus.ex_valid = 1'b1; bus.ex_stall = 1'b0; bus.ex_branch = 1'b1;
    bus.ex_branch_op = op; bus.ex_rs_data = rs; bus.ex_rt_data = rt;
    bus.ex_pc = pc; bus.ex_pred_taken = pred;
    bus.ex_target = pc + 32'h1000; bus.ex_fallthru = pc + 32'h8;
  endtask

  task automatic do_reset();
    idle();
    if_pc = '0;
    resetn = 1'b0;
    tick();
    tick();
    #2 resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b want 0", bus.flush); end
    checks++;
    if (bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %h want 0", bus.redirect_pc); end
    checks++;
    if (stat_branches !== 4'd0 || stat_mispred !== 4'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_branches, stat_mispred);
    end
    for (int i = 0; i < 64; i++) begin
      if_pc = i << 2;
      #1;
      checks++;
      if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred idx %0d got %0b want 0", i, if_pred_taken); end
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_ops();
    logic [3:0]  ops [12] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd0};
    logic [31:0] rss [12] = '{32'd5, 32'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd1,
                              32'd0, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd5};
    logic [31:0] rts [12] = '{32'd5, 32'd6, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5};
    logic        exp [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive_br(ops[i], rss[i], rts[i], 32'h40, 1'b0);
      bus.ex_valid = 1'b0;
      #1;
      checks++;
      if (bus.branch_en !== exp[i]) begin
        errors++; $display("FAIL op_vec %0d op %0d got %0b want %0b", i, ops[i], bus.branch_en, exp[i]);
      end
    end
    drive_br(4'd1, 32'd3, 32'd3, 32'h40, 1'b0);
    bus.ex_branch = 1'b0;
    #1;
    checks++;
    if (bus.branch_en !== 1'b0) begin errors++; $display("FAIL not_branch got %0b want 0", bus.branch_en); end
    idle();
  endtask

  task automatic test_bgtz_neg();
    do_reset();
    drive_br(4'd4, 32'hFFFFFFFF, 32'd0, 32'h100, 1'b1);
    #1;
    checks++;
    if (bus.branch_en !== 1'b0) begin errors++; $display("FAIL bgtz_neg_en got %0b want 0", bus.branch_en); end
    tick();
    idle();
    checks++;
    if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h108) begin
      errors++; $display("FAIL bgtz_flush got %0b/%h want 1/00000108", bus.flush, bus.redirect_pc);
    end
    checks++;
    if (stat_mispred !== 4'd1 || stat_branches !== 4'd1) begin
      errors++; $display("FAIL bgtz_stats got %0d/%0d want 1/1", stat_branches, stat_mispred);
    end
    tick();
    checks++;
    if (bus.flush !== 1'b0) begin errors++; $display("FAIL bgtz_pulse got %0b want 0", bus.flush); end
  endtask

  task automatic test_beq_train();
    int flushes = 0;
    do_reset();
    if_pc = 32'h100;
    for (int k = 0; k < 3; k++) begin
      drive_br(4'd1, 32'd5, 32'd5, 32'h100, 1'b0);
      #1;
      if (k == 0) begin
        checks++;
        if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL train_pre_pred got %0b want 0", if_pred_taken); end
      end
      tick();
      idle();
      if (bus.flush === 1'b1 && bus.redirect_pc === 32'h1100) flushes++;
      checks++;
      if (if_pred_taken !== 1'b1) begin errors++; $display("FAIL train_pred step %0d got %0b want 1", k, if_pred_taken); end
      tick();
    end
    checks++;
    if (flushes != 3 || stat_mispred !== 4'd3) begin
      errors++; $display("FAIL train_flushes got %0d/%0d want 3/3", flushes, stat_mispred);
    end
    drive_br(4'd1, 32'd5, 32'd6, 32'h100, 1'b1);
    tick();
    idle();
    checks++;
    if (if_pred_taken !== 1'b1 || bus.redirect_pc !== 32'h108) begin
      errors++; $display("FAIL train_sat got %0b/%h want 1/00000108", if_pred_taken, bus.redirect_pc);
    end
    tick();
    drive_br(4'd1, 32'd5, 32'd6, 32'h100, 1'b1);
    tick();
    idle();
    checks++;
    if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL train_down got %0b want 0", if_pred_taken); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_br(4'd2, 32'd1, 32'd1, 32'h80, 1'b1);
    tick();
    drive_br(4'd6, 32'hFFFFFFFF, 32'd0, 32'h200, 1'b0);
    checks++;
    if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h88) begin
      errors++; $display("FAIL b2b_first got %0b/%h want 1/00000088", bus.flush, bus.redirect_pc);
    end
    tick();
    idle();
    checks++;
    if (bus.flush !== 1'b0) begin errors++; $display("FAIL b2b_second got %0b want 0", bus.flush); end
    checks++;
    if (stat_branches !== 4'd1 || stat_mispred !== 4'd1) begin
      errors++; $display("FAIL b2b_stats got %0d/%0d want 1/1", stat_branches, stat_mispred);
    end
    if_pc = 32'h200;
    #1;
    checks++;
    if (if_pred_taken !== 1'b0) begin errors++; $display("FAIL b2b_bht got %0b want 0", if_pred_taken); end
  endtask

  task automatic test_stall();
    do_reset();
    if_pc = 32'h300;
    drive_br(4'd1, 32'd9, 32'd9, 32'h300, 1'b0);
    bus.ex_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.flush !== 1'b0 || stat_branches !== 4'd0 || if_pred_taken !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc %0d got %0b/%0d/%0b want 0/0/0", c, bus.flush, stat_branches, if_pred_taken);
      end
    end
    bus.ex_stall = 1'b0;
    tick();
    idle();
    checks++;
    if (bus.flush !== 1'b1 || stat_branches !== 4'd1 || if_pred_taken !== 1'b1) begin
      errors++; $display("FAIL stall_release got %0b/%0d/%0b want 1/1/1", bus.flush, stat_branches, if_pred_taken);
    end
    tick();
    checks++;
    if (bus.flush !== 1'b0 || stat_branches !== 4'd1) begin
      errors++; $display("FAIL stall_after got %0b/%0d want 0/1", bus.flush, stat_branches);
    end
  endtask

  task automatic test_jump();
    do_reset();
    if_pc = 32'h400;
    drive_br(4'd7, 32'd0, 32'd0, 32'h400, 1'b0);
    tick();
    idle();
    checks++;
    if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h1400 || if_pred_taken !== 1'b0) begin
      errors++; $display("FAIL j_mispred got %0b/%h/%0b want 1/00001400/0", bus.flush, bus.redirect_pc, if_pred_taken);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 20; n++) begin
      drive_br(4'd7, 32'd0, 32'd0, 32'h500, 1'b1);
      tick();
    end
    idle();
    checks++;
    if (stat_branches !== 4'd15 || stat_mispred !== 4'd0 || bus.flush !== 1'b0) begin
      errors++; $display("FAIL sat_count got %0d/%0d/%0b want 15/0/0", stat_branches, stat_mispred, bus.flush);
    end
    tick();
    checks++;
    if (stat_branches !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", stat_branches); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    drive_br(4'd1, 32'd1, 32'd1, 32'h600, 1'b0);
    tick();
    idle();
    checks++;
    if (bus.flush !== 1'b1) begin errors++; $display("FAIL midrst_pre got %0b want 1", bus.flush); end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (bus.flush !== 1'b0 || stat_branches !== 4'd0) begin
      errors++; $display("FAIL midrst_clear got %0b/%0d want 0/0", bus.flush, stat_branches);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ops();
    test_bgtz_neg();
    test_beq_train();
    test_back_to_back();
    test_stall();
    test_jump();
    test_saturation();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
